// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between write-back requesters and the register-bank port arbiter.
interface wb_port_arbiter_if #(
  parameter int unsigned N  = 24,
  parameter int unsigned A  = 4,
  parameter int unsigned R  = 3,
  parameter int unsigned CW = 16
);
  logic [R-1:0]   req;
  logic [R*A-1:0] req_addr;
  logic [R*N-1:0] req_data;
  logic [R-1:0]   gnt;
  logic           wr_en;
  logic [A-1:0]   wr_addr;
  logic [N-1:0]   wr_data;
  logic [CW-1:0]  conflict_cnt;

  modport master (
    output req, req_addr, req_data,
    input  gnt, wr_en, wr_addr, wr_data, conflict_cnt
  );

  modport slave (
    input  req, req_addr, req_data,
    output gnt, wr_en, wr_addr, wr_data, conflict_cnt
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin write-back port arbiter with registered write-port outputs.
// Define WB_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module wb_port_arbiter #(
    parameter int unsigned N  = 24,
    parameter int unsigned A  = 4,
    parameter int unsigned R  = 3,
    parameter int unsigned CW = 16
) (
    input logic clk,
    input logic rst,
    wb_port_arbiter_if.slave bus
);
    localparam int unsigned PW = (R > 1) ? $clog2(R) : 1;

    logic [PW-1:0] ptr;
    logic [R-1:0]  last;
    logic [R-1:0]  elig;
    logic          found;
    logic [PW-1:0] win;
    logic [R-1:0]  win_oh;
    logic          contended;
    logic          wr_en_q;
    logic [A-1:0]  wr_addr_q;
    logic [N-1:0]  wr_data_q;
    logic [CW-1:0] cnt_q;
    logic [A-1:0]  addr_arr [R];
    logic [N-1:0]  data_arr [R];

    for (genvar g = 0; g < R; g++) begin : g_unpack
        assign addr_arr[g] = bus.req_addr[g*A +: A];
        assign data_arr[g] = bus.req_data[g*N +: N];
    end

    // last doubles as the registered grant: a requester just granted is masked out
    assign elig      = bus.req & ~last;
    assign contended = ($countones(elig) >= 2);

    always_comb begin
        int unsigned cand;
        cand  = 0;
        found = 1'b0;
        win   = '0;
        for (int unsigned off = 0; off < R; off++) begin
            cand = 32'(ptr) + off;
            if (cand >= R) cand = cand - R;
            if (!found && elig[cand[PW-1:0]]) begin
                found = 1'b1;
                win   = cand[PW-1:0];
            end
        end
        win_oh = found ? (R'(1) << win) : '0;
    end

`ifdef WB_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (32'(win) + 1 >= R) ? '0 : win + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            cnt_q     <= '0;
        end else begin
            last    <= win_oh;
            wr_en_q <= found;
            if (found) begin
                wr_addr_q <= addr_arr[win];
                wr_data_q <= data_arr[win];
            end
            if (contended && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.gnt          = last;
    assign bus.wr_en        = wr_en_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.conflict_cnt = cnt_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed and randomized bench for wb_port_arbiter against an integer-level grant model.
module tb_wb_port_arbiter;
    localparam int unsigned N  = 24;
    localparam int unsigned A  = 4;
    localparam int unsigned R  = 3;
    localparam int unsigned CW = 5;
    localparam int CNT_MAX = (1 << CW) - 1;
`ifdef WB_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_port_arbiter_if #(.N(N), .A(A), .R(R), .CW(CW)) bus ();
    wb_port_arbiter #(.N(N), .A(A), .R(R), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // requester-side stimulus state
    bit           r_req  [R];
    logic [A-1:0] r_addr [R];
    logic [N-1:0] r_data [R];

    // reference model state
    int           m_ptr, m_last, m_cnt, m_win;
    logic [R-1:0] exp_gnt;
    logic         exp_we;
    logic [A-1:0] exp_addr;
    logic [N-1:0] exp_data;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_last = -1; m_cnt = 0; m_win = -1;
        exp_gnt = '0; exp_we = 1'b0; exp_addr = '0; exp_data = '0;
    endtask

    task automatic model_eval();
        int ne, start;
        ne = 0; m_win = -1;
        start = FIXED ? 0 : m_ptr;
        for (int i = 0; i < R; i++) if (r_req[i] && i != m_last) ne++;
        for (int k = 0; k < R; k++) begin
            int i;
            i = (start + k) % R;
            if (m_win < 0 && r_req[i] && i != m_last) m_win = i;
        end
        if (ne >= 2 && m_cnt < CNT_MAX) m_cnt++;
        if (m_win >= 0) begin
            exp_gnt  = R'(1) << m_win;
            exp_we   = 1'b1;
            exp_addr = r_addr[m_win];
            exp_data = r_data[m_win];
            m_ptr    = (m_win + 1) % R;
            m_last   = m_win;
        end else begin
            exp_gnt = '0;
            exp_we  = 1'b0;
            m_last  = -1;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < R; i++) begin
            bus.req[i]              = r_req[i];
            bus.req_addr[i*A +: A]  = r_addr[i];
            bus.req_data[i*N +: N]  = r_data[i];
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".gnt"},  64'(bus.gnt),          64'(exp_gnt));
        chk({tag, ".we"},   64'(bus.wr_en),        64'(exp_we));
        chk({tag, ".addr"}, 64'(bus.wr_addr),      64'(exp_addr));
        chk({tag, ".data"}, 64'(bus.wr_data),      64'(exp_data));
        chk({tag, ".cnt"},  64'(bus.conflict_cnt), 64'(m_cnt));
    endtask

    // one arbitration edge: inputs stable before posedge, outputs sampled 1 time unit after
    task automatic step(input string tag);
        drive();
        @(posedge clk);
        model_eval();
        #1;
        check_model(tag);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".gnt0"},  64'(bus.gnt),          64'(0));
        chk({tag, ".we0"},   64'(bus.wr_en),        64'(0));
        chk({tag, ".addr0"}, 64'(bus.wr_addr),      64'(0));
        chk({tag, ".data0"}, 64'(bus.wr_data),      64'(0));
        chk({tag, ".cnt0"},  64'(bus.conflict_cnt), 64'(0));
    endtask

    task automatic do_reset(input string tag);
        drive();
        rst = 1'b1;
        #1;
        model_reset();
        check_zero(tag);
        @(posedge clk);
        #1;
        check_zero(tag);
        rst = 1'b0;
    endtask

    task automatic set_req(input logic [R-1:0] v);
        for (int i = 0; i < R; i++) r_req[i] = v[i];
    endtask

    initial begin
        for (int i = 0; i < R; i++) begin
            r_req[i] = 1'b0; r_addr[i] = '0; r_data[i] = '0;
        end
        drive();
        model_reset();
        do_reset("rst");

        for (int k = 0; k < 5; k++) begin
            step("idle");
            chk("idle.gnt_c", 64'(bus.gnt), 64'(0));
        end

        r_req[0] = 1'b1; r_addr[0] = 4'd5; r_data[0] = 24'hABCDEF;
        for (int k = 1; k <= 5; k++) begin
            step("single");
            chk("single.gnt_c", 64'(bus.gnt), (k % 2) ? 64'(1) : 64'(0));
            chk("single.cnt_c", 64'(bus.conflict_cnt), 64'(0));
        end
        chk("single.addr_c", 64'(bus.wr_addr), 64'(5));
        chk("single.data_c", 64'(bus.wr_data), 64'hABCDEF);

        for (int i = 0; i < R; i++) begin
            r_addr[i] = A'(i + 1); r_data[i] = N'(32'h100 + i);
        end
        set_req(3'b111);
        do_reset("rst3");
        for (int k = 0; k < 6; k++) begin
            step("all");
            if (FIXED) chk("all.gnt_c", 64'(bus.gnt), 64'(1 << (k % 2)));
            else       chk("all.gnt_c", 64'(bus.gnt), 64'(1 << (k % 3)));
            chk("all.cnt_c", 64'(bus.conflict_cnt), 64'(k + 1));
            chk("all.we_c",  64'(bus.wr_en), 64'(1));
        end

        // reset asserted mid-stream while all three keep requesting
        rst = 1'b1;
        #1;
        model_reset();
        check_zero("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("after_rst");
        chk("after_rst.gnt_c", 64'(bus.gnt), 64'(1));
        chk("after_rst.cnt_c", 64'(bus.conflict_cnt), 64'(1));
        for (int k = 0; k < 40; k++) step("sat");
        chk("sat.cnt_c", 64'(bus.conflict_cnt), 64'(CNT_MAX));

        set_req(3'b110);
        do_reset("rst4");
        step("two");
        chk("two.gnt_c", 64'(bus.gnt), 64'(2));
        r_req[1] = 1'b0;
        step("two");
        chk("two.gnt_c2", 64'(bus.gnt), 64'(4));
        step("two");
        chk("two.gnt_c3", 64'(bus.gnt), 64'(0));
        step("two");
        chk("two.gnt_c4", 64'(bus.gnt), 64'(4));

        set_req(3'b000);
        do_reset("rst5");
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < R; i++) begin
                if (!r_req[i] && ($urandom % 3 == 0)) begin
                    r_req[i]  = 1'b1;
                    r_addr[i] = A'($urandom);
                    r_data[i] = N'($urandom);
                end
            end
            step("rand");
            if (m_win >= 0) begin
                if ($urandom % 2 == 0) begin
                    r_req[m_win] = 1'b0;
                end else begin
                    r_addr[m_win] = A'($urandom);
                    r_data[m_win] = N'($urandom);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Write-back port arbiter for the processor's register storage. Several pipeline sources contend for the single write port of a register bank: scalar ALU, vector lanes and memory load return. The arbiter picks one requester per cycle with round-robin, and drives the port's write-enable, address and data from registers. Registers capture on the falling edge, so the arbiter decides on the rising edge and its outputs are stable before that same cycle's negedge write.

## Interface
- N, 24, data width of a register entry
- A, 4, register address width (2^A entries)
- R, 3, number of requesters (≥2)
- CW, 16, width of the conflict statistics counter
- clk  in  1  clock; arbitration on posedge
- rst  in  1  reset, asynchronous, active-high
- req  in  R  per-requester write request; held until granted
- req_addr  in  R*A  packed addresses; requester i at [i*A +: A]
- req_data  in  R*N  packed data; requester i at [i*N +: N]
- gnt  out  R  one-hot grant pulse, one cycle, registered
- wr_en  out  1  write enable to register bank, registered
- wr_addr  out  A  write address, registered
- wr_data  out  N  write data, registered
- conflict_cnt  out  CW  saturating count of contended cycles

## Operation
- Internal state:
  - ptr: round-robin pointer, range 0..R-1
  - last: one-hot copy of the previous cycle's gnt
- Eligible set at each posedge: elig = req & ~last.
  - A requester granted in cycle k is ineligible in cycle k+1. This prevents a double grant while the requester is still dropping req.
- Selection: search elig starting at index ptr, ascending, wrapping mod R. The first set bit wins.
- On a win by requester w:
  - gnt = one-hot(w), wr_en = 1
  - wr_addr = req_addr[w], wr_data = req_data[w]
  - ptr ← (w+1) mod R
  - last ← one-hot(w)
- If elig == 0:
  - gnt = 0, wr_en = 0
  - wr_addr and wr_data hold their previous values
  - ptr unchanged, last ← 0
- conflict_cnt increments by 1 on every posedge where popcount(elig) ≥ 2. It saturates at 2^CW−1 and does not wrap.
- Requester contract:
  - Keep req, addr and data stable until gnt[i] is seen high.
  - req may stay high after a grant to request a further write. That write is taken no earlier than the cycle after next.
- Address collisions between requesters are not checked. The write order equals the grant order.

## Timing
- Latency: req sampled at posedge k gives gnt, wr_en and wr_addr/wr_data valid from posedge k through posedge k+1. The bank writes at the negedge inside cycle k.
- Throughput:
  - One write per cycle when ≥2 requesters are active.
  - One write per two cycles for a single continuously active requester.
- Reset, while rst is high and taking effect immediately:
  - gnt = 0, wr_en = 0, wr_addr = 0, wr_data = 0
  - conflict_cnt = 0, ptr = 0, last = 0
- Reset mid-operation: any in-flight grant is cancelled. Requesters still holding req are evaluated at the first posedge after rst falls, starting from ptr = 0.
- A request rising in the same cycle as another requester's grant competes normally at the next edge.

## Configuration
- Macro WB_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest eligible index wins and ptr is unused (tied to 0). The last-grant mask still applies.
- Undefined (default): round-robin as described above.

## Test plan
- Reset, no req for 5 cycles -> gnt=000, wr_en=0, wr_addr=0, wr_data=0, conflict_cnt=0 throughout.
- req=001 held, req_addr[0]=5, req_data[0]=0xABCDEF -> gnt=001 and wr_en=1 on cycles 1,3,5, idle on 2,4; wr_addr=5, wr_data=0xABCDEF; conflict_cnt stays 0.
- req=111 held from reset with distinct addresses 1,2,3 -> grants 0,1,2,0,1,2, wr_en=1 every cycle, conflict_cnt +1 every cycle.
- After reset, req=110 -> grant 1 then 2; with req=100 held alone thereafter -> grant 2 every other cycle.
- req=111, assert rst at cycle 3 for one cycle -> all outputs 0 immediately; first grant after release is requester 0; conflict_cnt restarts from 0.
- WB_ARB_FIXED_PRIO_EN defined, req=111 held -> grants 0,1,0,1; requester 2 is never granted while 0 and 1 stay active.
